// File: rtl/seg7_pkg.sv
// Shared character codes, segment patterns and shadow-register layout for the
// seven-segment scan driver.
package seg7_pkg;

   localparam int NUM_DIGITS = 8;

   localparam logic [4:0] CH_BLANK = 5'd16;
   localparam logic [4:0] CH_DASH  = 5'd17;
   localparam logic [4:0] CH_R     = 5'd18;
   localparam logic [4:0] CH_O     = 5'd19;
   localparam logic [4:0] CH_N     = 5'd20;
   localparam logic [4:0] CH_P     = 5'd21;
   localparam logic [4:0] CH_L     = 5'd22;
   localparam logic [4:0] CH_H     = 5'd23;
   localparam logic [4:0] CH_U     = 5'd24;
   localparam logic [4:0] CH_T     = 5'd25;

   // {g,f,e,d,c,b,a}; entry 15 first so SEG_HEX[n] is the glyph for hex n
   localparam logic [15:0][6:0] SEG_HEX = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
   localparam logic [6:0] SEG_OFF  = 7'h00;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_R    = 7'h50;
   localparam logic [6:0] SEG_O    = 7'h5C;
   localparam logic [6:0] SEG_N    = 7'h54;
   localparam logic [6:0] SEG_P    = 7'h73;
   localparam logic [6:0] SEG_L    = 7'h38;
   localparam logic [6:0] SEG_H    = 7'h76;
   localparam logic [6:0] SEG_U    = 7'h3E;
   localparam logic [6:0] SEG_T    = 7'h78;

   typedef struct packed {
      logic [NUM_DIGITS-1:0][4:0] code;
      logic [NUM_DIGITS-1:0]      dp;
      logic [NUM_DIGITS-1:0]      blink;
   } shadow_t;

endpackage

// File: rtl/seg7_char_decode.sv
// Character code to {g..a} segment pattern; codes without a glyph stay dark.
module seg7_char_decode
   import seg7_pkg::*;
(
   input  logic [4:0] code,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      if (code < 5'd16) begin
         seg = SEG_HEX[code[3:0]];
      end else begin
         case (code)
            CH_DASH: seg = SEG_DASH;
            CH_R:    seg = SEG_R;
            CH_O:    seg = SEG_O;
            CH_N:    seg = SEG_N;
            CH_P:    seg = SEG_P;
            CH_L:    seg = SEG_L;
            CH_H:    seg = SEG_H;
            CH_U:    seg = SEG_U;
            CH_T:    seg = SEG_T;
            default: seg = SEG_OFF;
         endcase
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Scanned 8-digit seven-segment driver with frame-synchronous shadow data,
// anti-ghost blank interval at the start of each slot and per-digit blink.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DIGIT_CYCLES = 100_000,
   parameter int BLANK_CYCLES = 1_000,
   parameter int BLINK_CYCLES = 50_000_000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [NUM_DIGITS*5-1:0]    digits_in,
   input  logic [NUM_DIGITS-1:0]      dp_in,
   input  logic [NUM_DIGITS-1:0]      blink_in,
   output logic [NUM_DIGITS-1:0]      an,
   output logic [7:0]                 seg,
   output logic                       frame_done
);

   localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_BLK = CNT_W'(BLANK_CYCLES);
   localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_CYCLES - 1);

   logic [CNT_W-1:0] cnt;
   logic [2:0]       idx;
   logic [BLK_W-1:0] blink_cnt;
   logic             blink_ph;
   logic             en_q;
   shadow_t          sh;

   logic             frame_end, reload, lit;
   logic [6:0]       glyph;

   // enable-rise and frame-end collapse into one reload
   assign frame_end = (cnt == CNT_MAX) && (idx == 3'd7);
   assign reload    = en && (!en_q || frame_end);
   assign lit       = en_q && (cnt >= CNT_BLK) && !(blink_ph && sh.blink[idx]);

   seg7_char_decode u_dec (
      .code (sh.code[idx]),
      .seg  (glyph)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         idx        <= '0;
         blink_cnt  <= '0;
         blink_ph   <= 1'b0;
         en_q       <= 1'b0;
         sh.code    <= {NUM_DIGITS{CH_BLANK}};
         sh.dp      <= '0;
         sh.blink   <= '0;
         an         <= '0;
         seg        <= '0;
         frame_done <= 1'b0;
      end else begin
         en_q       <= en;
         frame_done <= reload;
         if (reload) begin
            sh.code  <= digits_in;
            sh.dp    <= dp_in;
            sh.blink <= blink_in;
         end

         if (!en) begin
            cnt <= '0;
            idx <= '0;
         end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= idx + 3'd1;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end

         // blink keeps time even while the display is disabled
         if (blink_cnt == BLK_MAX) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
         end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
         end

         an  <= lit ? (8'd1 << idx) : '0;
         seg <= lit ? {sh.dp[idx], glyph} : '0;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a time-based reference model.
module tb_seg7_scan_driver;

   localparam int DC = 10;
   localparam int BC = 2;
   localparam int BK = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en  = 1'b0;
   logic [39:0] digits_in = '0;
   logic [7:0]  dp_in = '0;
   logic [7:0]  blink_in = '0;
   logic [7:0]  an;
   logic [7:0]  seg;
   logic        frame_done;

   int n_chk  = 0;
   int n_pass = 0;

   seg7_scan_driver #(
      .DIGIT_CYCLES (DC),
      .BLANK_CYCLES (BC),
      .BLINK_CYCLES (BK)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .blink_in   (blink_in),
      .an         (an),
      .seg        (seg),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // model: m_t = consecutive enabled edges, m_n = edges since reset
   bit         m_enq;
   int         m_t;
   int         m_n;
   logic [4:0] m_code [8];
   logic [7:0] m_dp;
   logic [7:0] m_blink;
   logic [7:0] prev_an;

   function automatic logic [6:0] glyph(input logic [4:0] c);
      case (c)
         5'd0:  return 7'h3F;  5'd1:  return 7'h06;  5'd2:  return 7'h5B;
         5'd3:  return 7'h4F;  5'd4:  return 7'h66;  5'd5:  return 7'h6D;
         5'd6:  return 7'h7D;  5'd7:  return 7'h07;  5'd8:  return 7'h7F;
         5'd9:  return 7'h6F;  5'd10: return 7'h77;  5'd11: return 7'h7C;
         5'd12: return 7'h39;  5'd13: return 7'h5E;  5'd14: return 7'h79;
         5'd15: return 7'h71;  5'd17: return 7'h40;  5'd18: return 7'h50;
         5'd19: return 7'h5C;  5'd20: return 7'h54;  5'd21: return 7'h73;
         5'd22: return 7'h38;  5'd23: return 7'h76;  5'd24: return 7'h3E;
         5'd25: return 7'h78;
         default: return 7'h00;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_enq = 1'b0;
      m_t   = 0;
      m_n   = 0;
      for (int i = 0; i < 8; i++) m_code[i] = 5'd16;
      m_dp    = '0;
      m_blink = '0;
      prev_an = '0;
   endtask

   task automatic step();
      int         slot_pos, dig;
      bit         ph, lit, rel;
      logic [7:0] e_an, e_seg;
      slot_pos = m_t % DC;
      dig      = (m_t / DC) % 8;
      ph       = ((m_n / BK) % 2) == 1;
      rel      = en && (!m_enq || (m_t % (8 * DC)) == 8 * DC - 1);
      lit      = m_enq && slot_pos >= BC && !(ph && m_blink[dig]);
      e_an     = lit ? 8'(1 << dig) : 8'h00;
      e_seg    = lit ? {m_dp[dig], glyph(m_code[dig])} : 8'h00;
      @(posedge clk);
      #1;
      chk("an", 32'(an), 32'(e_an));
      chk("seg", 32'(seg), 32'(e_seg));
      chk("frame_done", 32'(frame_done), 32'(rel));
      chk("an_onehot", 32'($countones(an) <= 1), 32'd1);
      chk("an_gap", 32'(an != 0 && prev_an != 0 && an != prev_an), 32'd0);
      prev_an = an;
      if (rel) begin
         for (int i = 0; i < 8; i++) m_code[i] = digits_in[5*i +: 5];
         m_dp    = dp_in;
         m_blink = blink_in;
      end
      m_enq = en;
      m_t   = en ? m_t + 1 : 0;
      m_n++;
   endtask

   // advance until the state about to be displayed is slot w_dig at w_pos
   task automatic wait_slot(input int w_dig, input int w_pos);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         if (m_enq && (m_t % DC) == w_pos && ((m_t / DC) % 8) == w_dig) found = 1'b1;
         else step();
      end
      chk("wait_slot", 32'(found), 32'd1);
   endtask

   initial begin
      model_reset();
      #1 rst = 1'b1;
      #2;
      chk("rst_an", 32'(an), 32'd0);
      chk("rst_seg", 32'(seg), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();

      // hex 0..7 on digits 0..7
      en = 1'b1;
      for (int i = 0; i < 8; i++) digits_in[5*i +: 5] = 5'(i);
      repeat (90) step();

      // input changes mid-frame must wait for the next reload
      for (int k = 0; k < 300; k++) begin
         if (k % 13 == 5) begin
            digits_in = {$urandom(), $urandom()};
            dp_in     = 8'($urandom());
         end
         step();
      end

      // blink digit 0 across several phase changes
      digits_in = {8{5'd8}};
      dp_in     = '0;
      blink_in  = 8'h01;
      repeat (400) step();

      // decimal point on a blank character
      blink_in = '0;
      dp_in    = 8'h04;
      digits_in = {$urandom(), $urandom()};
      digits_in[14:10] = 5'd16;
      repeat (170) step();

      // drop enable mid slot 5 for 7 cycles
      wait_slot(5, 4);
      en = 1'b0;
      repeat (7) step();
      en = 1'b1;
      repeat (100) step();

      // async reset while digit 3 is lit
      wait_slot(3, 5);
      step();
      chk("lit_before_rst", 32'(an), 32'h08);
      rst = 1'b1;
      #2;
      chk("rst_async_an", 32'(an), 32'd0);
      chk("rst_async_seg", 32'(seg), 32'd0);
      rst = 1'b0;
      model_reset();
      repeat (100) step();

      // free-running random traffic
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 49) == 0) en = ~en;
         if ($urandom_range(0, 9) == 0) begin
            digits_in = {$urandom(), $urandom()};
            dp_in     = 8'($urandom());
            blink_in  = 8'($urandom());
         end
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
